// File: rtl/vram_pkg.sv
// Shared VRAM arbitration types and default geometry for the line prefetch path.
package vram_pkg;
   localparam int WORDS_PER_LINE = 160;
   localparam int ADDR_W         = 16;
   localparam int DATA_W         = 16;
   localparam int IDX_W          = 8;
   localparam int ROW_W          = 9;

   typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_CPU} tag_t;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/vram_return_pipe.sv
// Tag/index delay line: says who owns the VRAM read data arriving LATENCY
// cycles after a strobe. A flush drops fetch tags but keeps CPU tags.
module vram_return_pipe
   import vram_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  tag_t             i_tag,
   input  logic [IDX_W-1:0] i_idx,
   input  logic             i_flush,
   output tag_t             o_tag,
   output logic [IDX_W-1:0] o_idx
);
   tag_t             r_tag [LATENCY];
   logic [IDX_W-1:0] r_idx [LATENCY];

   // NOTE: these stages are reset, unlike a data RAM, because a stale tag would fire a spurious lbWe or cpuAck.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_tag[i] <= TAG_NONE;
            r_idx[i] <= '0;
         end
      end else begin
         r_tag[0] <= (i_flush && i_tag == TAG_FETCH) ? TAG_NONE : i_tag;
         r_idx[0] <= i_idx;
         for (int i = 1; i < LATENCY; i++) begin
            r_tag[i] <= (i_flush && r_tag[i-1] == TAG_FETCH) ? TAG_NONE : r_tag[i-1];
            r_idx[i] <= r_idx[i-1];
         end
      end
   end

   assign o_tag = r_tag[LATENCY-1];
   assign o_idx = r_idx[LATENCY-1];
endmodule

// File: rtl/line_fetch_arbiter.sv
// Shares one VRAM port between the next-row prefetch into a ping-pong line
// buffer and a CPU requester; swaps buffer halves at each line start.
module line_fetch_arbiter
   import vram_pkg::*;
#(
   parameter int WORDS_PER_LINE = vram_pkg::WORDS_PER_LINE,
   parameter int ADDR_W         = vram_pkg::ADDR_W,
   parameter int DATA_W         = vram_pkg::DATA_W,
   parameter int BASE_ADDR      = 0,
   parameter int MEM_LATENCY    = 1
) (
   input  logic              clkPixel,
   input  logic              reset,
   input  logic              lineStart,
   input  logic              fetchValid,
   input  logic [ROW_W-1:0]  fetchRow,
   input  logic              cpuReq,
   input  logic              cpuWe,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWData,
   output logic              cpuAck,
   output logic [DATA_W-1:0] cpuRData,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memRead,
   output logic              memWrite,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,
   output logic              lbWe,
   output logic [8:0]        lbAddr,
   output logic [DATA_W-1:0] lbData,
   output logic              frontBank,
   output logic              overrun
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_count;
   logic [ROW_W-1:0]   r_back_row, r_front_row;
   logic               r_back_ready, r_front_row_valid, r_front_bank, r_overrun;
   logic               r_last_fetch, r_cpu_busy, r_cpu_is_read;
   logic               r_mem_read, r_mem_write;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_wdata, r_cpu_rdata;
   tag_t               r_issue_tag;
   logic [IDX_W-1:0]   r_issue_idx;

   tag_t               w_ret_tag;
   logic [IDX_W-1:0]   w_ret_idx;
   logic               w_abort, w_swap, w_start_fetch, w_front_valid_nxt;
   logic [ROW_W-1:0]   w_front_row_nxt;
   logic               w_cpu_want, w_fetch_want, w_grant_cpu, w_grant_fetch;
   logic               w_ret_fetch, w_ret_cpu;
   logic [ADDR_W-1:0]  w_fetch_addr;

   vram_return_pipe #(.LATENCY(MEM_LATENCY)) u_return_pipe (
      .i_clk   (clkPixel),
      .i_rst   (reset),
      .i_tag   (r_issue_tag),
      .i_idx   (r_issue_idx),
      .i_flush (w_abort),
      .o_tag   (w_ret_tag),
      .o_idx   (w_ret_idx)
   );

   // A line start that lands mid-fetch aborts it; its returns must never reach the buffer.
   assign w_abort           = lineStart && (r_state != IDLE);
   assign w_swap            = lineStart && !w_abort && r_back_ready;
   assign w_front_row_nxt   = w_swap ? r_back_row : r_front_row;
   assign w_front_valid_nxt = w_swap || r_front_row_valid;
   assign w_start_fetch     = lineStart && fetchValid &&
                              !(w_front_valid_nxt && fetchRow == w_front_row_nxt);

   assign w_cpu_want    = cpuReq && !r_cpu_busy;
   assign w_fetch_want  = (r_state == FETCH) && !lineStart;
   assign w_grant_cpu   = w_cpu_want && (!w_fetch_want || r_last_fetch);
   assign w_grant_fetch = w_fetch_want && !w_grant_cpu;
   assign w_fetch_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_back_row) * ADDR_W'(WORDS_PER_LINE)
                          + ADDR_W'(r_count);

   assign w_ret_fetch = (w_ret_tag == TAG_FETCH) && !w_abort;
   assign w_ret_cpu   = (w_ret_tag == TAG_CPU);

   // NOTE: every output is given a default first so no path through this block infers a latch.
   always_comb begin
      cpuAck   = w_ret_cpu;
      cpuRData = r_cpu_rdata;
      lbWe     = w_ret_fetch;
      lbAddr   = '0;
      lbData   = '0;
      if (w_ret_cpu && r_cpu_is_read) cpuRData = memRData;
      if (w_ret_fetch) begin
         lbAddr = {~r_front_bank, w_ret_idx};
         lbData = memRData;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clkPixel or posedge reset) begin
      if (reset) begin
         r_state           <= IDLE;
         r_count           <= '0;
         r_back_row        <= '0;
         r_front_row       <= '0;
         r_back_ready      <= 1'b0;
         r_front_row_valid <= 1'b0;
         r_front_bank      <= 1'b0;
         r_overrun         <= 1'b0;
         r_last_fetch      <= 1'b0;
         r_cpu_busy        <= 1'b0;
         r_cpu_is_read     <= 1'b0;
         r_mem_read        <= 1'b0;
         r_mem_write       <= 1'b0;
         r_mem_addr        <= '0;
         r_mem_wdata       <= '0;
         r_cpu_rdata       <= '0;
         r_issue_tag       <= TAG_NONE;
         r_issue_idx       <= '0;
      end else begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_issue_tag <= TAG_NONE;
         if (w_grant_cpu) begin
            r_mem_addr    <= cpuAddr;
            r_mem_wdata   <= cpuWData;
            r_mem_read    <= !cpuWe;
            r_mem_write   <= cpuWe;
            r_issue_tag   <= TAG_CPU;
            r_cpu_busy    <= 1'b1;
            r_cpu_is_read <= !cpuWe;
            r_last_fetch  <= 1'b0;
         end else if (w_grant_fetch) begin
            r_mem_addr   <= w_fetch_addr;
            r_mem_read   <= 1'b1;
            r_issue_tag  <= TAG_FETCH;
            r_issue_idx  <= r_count;
            r_last_fetch <= 1'b1;
         end

         if (w_ret_cpu) begin
            r_cpu_busy <= 1'b0;
            if (r_cpu_is_read) r_cpu_rdata <= memRData;
         end

         if (lineStart) begin
            if (w_abort) begin
               r_overrun    <= 1'b1;
               r_back_ready <= 1'b0;
            end else if (r_back_ready) begin
               r_front_bank      <= ~r_front_bank;
               r_front_row       <= r_back_row;
               r_front_row_valid <= 1'b1;
               r_back_ready      <= 1'b0;
            end
            if (w_start_fetch) begin
               r_state    <= FETCH;
               r_count    <= '0;
               r_back_row <= fetchRow;
            end else begin
               r_state <= IDLE;
            end
         end else begin
            case (r_state)
               FETCH: if (w_grant_fetch) begin
                  if (r_count == LAST_IDX) r_state <= DRAIN;
                  else                     r_count <= r_count + 1'b1;
               end
               DRAIN: if (w_ret_fetch && w_ret_idx == LAST_IDX) begin
                  r_back_ready <= 1'b1;
                  r_state      <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign memAddr   = r_mem_addr;
   assign memRead   = r_mem_read;
   assign memWrite  = r_mem_write;
   assign memWData  = r_mem_wdata;
   assign frontBank = r_front_bank;
   assign overrun   = r_overrun;
endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Scoreboard bench for line_fetch_arbiter: stimulus pushes expected fetch
// addresses, line-buffer writes and CPU read data; a negedge monitor checks them.
module tb_line_fetch_arbiter;
   localparam int LAT = 1;
   localparam int WPL = 160;

   logic        clkPixel = 1'b0;
   logic        reset = 1'b1;
   logic        lineStart = 1'b0;
   logic        fetchValid = 1'b0;
   logic [8:0]  fetchRow = '0;
   logic        cpuReq = 1'b0;
   logic        cpuWe = 1'b0;
   logic [15:0] cpuAddr = '0;
   logic [15:0] cpuWData = '0;
   logic        cpuAck;
   logic [15:0] cpuRData;
   logic [15:0] memAddr;
   logic        memRead;
   logic        memWrite;
   logic [15:0] memWData;
   logic [15:0] memRData;
   logic        lbWe;
   logic [8:0]  lbAddr;
   logic [15:0] lbData;
   logic        frontBank;
   logic        overrun;

   line_fetch_arbiter #(
      .WORDS_PER_LINE (WPL),
      .ADDR_W         (16),
      .DATA_W         (16),
      .BASE_ADDR      (0),
      .MEM_LATENCY    (LAT)
   ) dut (
      .clkPixel (clkPixel), .reset (reset), .lineStart (lineStart),
      .fetchValid (fetchValid), .fetchRow (fetchRow), .cpuReq (cpuReq),
      .cpuWe (cpuWe), .cpuAddr (cpuAddr), .cpuWData (cpuWData),
      .cpuAck (cpuAck), .cpuRData (cpuRData), .memAddr (memAddr),
      .memRead (memRead), .memWrite (memWrite), .memWData (memWData),
      .memRData (memRData), .lbWe (lbWe), .lbAddr (lbAddr), .lbData (lbData),
      .frontBank (frontBank), .overrun (overrun)
   );

   always #5 clkPixel = ~clkPixel;

   // Single-port synchronous VRAM model, one cycle read latency.
   logic [15:0] vram [65536];
   logic [15:0] mem_rdata = '0;
   assign memRData = mem_rdata;
   always @(posedge clkPixel) begin
      if (memWrite) vram[memAddr] <= memWData;
      if (memRead)  mem_rdata <= vram[memAddr];
   end

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          cpu_grant_cyc = 0;
   bit          fetch_done = 1'b0;
   int          cpu_ops = 0;
   logic [15:0] exp_last_rdata = '0;
   logic [15:0] fa_q [$];
   logic [24:0] lb_q [$];
   logic [15:0] cpu_q [$];

   function automatic logic [15:0] pat(input int a);
      return 16'(a) ^ 16'hA5A5;
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic logic [95:0] all_outs();
      return 96'({cpuAck, cpuRData, memAddr, memRead, memWrite, memWData,
                  lbWe, lbAddr, lbData, frontBank, overrun});
   endfunction

   task automatic push_fetch(input int row, input logic bank);
      for (int i = 0; i < WPL; i++) begin
         fa_q.push_back(16'(row * WPL + i));
         lb_q.push_back({bank, 8'(i), pat(row * WPL + i)});
      end
   endtask

   task automatic line_start(input logic valid, input logic [8:0] row);
      @(posedge clkPixel); #1;
      lineStart = 1'b1; fetchValid = valid; fetchRow = row;
      @(posedge clkPixel); #1;
      lineStart = 1'b0; fetchValid = 1'b0;
   endtask

   task automatic wait_fetch(output int n);
      n = 0;
      while ((fa_q.size() != 0 || lb_q.size() != 0) && n < 400) begin
         @(negedge clkPixel);
         n++;
      end
      if (n >= 400) fail_now("fetch_timeout");
   endtask

   task automatic wait_ack();
      int n;
      n = 0;
      do begin
         @(negedge clkPixel);
         n++;
      end while (!cpuAck && n < 20);
      if (!cpuAck) fail_now("cpu_ack_timeout");
   endtask

   task automatic cpu_op(input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rd);
      cpu_q.push_back(exp_rd);
      @(posedge clkPixel); #1;
      cpuWe = we; cpuAddr = addr; cpuWData = wdata; cpuReq = 1'b1;
      wait_ack();
      @(posedge clkPixel); #1;
      cpuReq = 1'b0;
   endtask

   // Monitor: fetch reads are below 0x1000, CPU traffic is above it.
   always @(negedge clkPixel) begin
      cyc++;
      if (memRead && !memWrite && memAddr < 16'h1000) begin
         if (fa_q.size() == 0) fail_now("fetch_read_unexpected");
         else check("fetch_addr", 96'(memAddr), 96'(fa_q.pop_front()));
      end else if (memRead || memWrite) begin
         cpu_grant_cyc = cyc;
      end
      if (lbWe) begin
         if (lb_q.size() == 0) fail_now("lb_write_unexpected");
         else check("lb_write", 96'({lbAddr, lbData}), 96'(lb_q.pop_front()));
      end
      if (cpuAck) begin
         if (cpu_q.size() == 0) fail_now("cpu_ack_unexpected");
         else begin
            check("cpu_ack_latency", 96'(cyc - cpu_grant_cyc), 96'(LAT));
            check("cpu_rdata", 96'(cpuRData), 96'(cpu_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int a = 0; a < 65536; a++) vram[a] = pat(a);

      // Reset state
      repeat (3) @(posedge clkPixel);
      #1;
      check("reset_outputs", all_outs(), '0);
      reset = 1'b0;
      @(negedge clkPixel);
      check("post_reset_outputs", all_outs(), '0);

      // Plain fetch of row 5 into bank 1
      push_fetch(5, 1'b1);
      line_start(1'b1, 9'd5);
      wait_fetch(n);
      check("fetchA_in_time", 96'(n <= 170), 96'(1));
      repeat (5) @(posedge clkPixel);
      #1;
      check("fetchA_front_before", 96'(frontBank), 96'(0));
      line_start(1'b1, 9'd5);
      check("swap_front_bank", 96'(frontBank), 96'(1));
      repeat (20) @(posedge clkPixel);
      line_start(1'b1, 9'd5);
      repeat (20) @(posedge clkPixel);
      #1;
      check("repeat_row_no_toggle", 96'(frontBank), 96'(1));
      check("no_overrun_yet", 96'(overrun), 96'(0));

      // Fetch row 7 into bank 0 with CPU reads held continuously
      push_fetch(7, 1'b0);
      line_start(1'b1, 9'd7);
      fetch_done = 1'b0;
      fork
         begin
            int nf;
            wait_fetch(nf);
            check("contended_fetch_le_320", 96'(nf <= 320), 96'(1));
            fetch_done = 1'b1;
         end
         begin
            int k;
            k = 0;
            while (!fetch_done) begin
               cpu_q.push_back(pat(16'h4000 + k));
               exp_last_rdata = pat(16'h4000 + k);
               cpuWe = 1'b0; cpuAddr = 16'(16'h4000 + k); cpuReq = 1'b1;
               wait_ack();
               @(posedge clkPixel); #1;
               k++;
            end
            cpuReq = 1'b0;
            cpu_ops = k;
         end
      join
      check("cpu_not_starved", 96'(cpu_ops >= 40), 96'(1));
      check("contended_front_bank", 96'(frontBank), 96'(1));

      // CPU write then read back
      cpu_op(1'b1, 16'h1234, 16'hBEEF, exp_last_rdata);
      cpu_op(1'b0, 16'h1234, 16'h0000, 16'hBEEF);
      exp_last_rdata = 16'hBEEF;

      // Overrun: row 9 into bank 1, aborted 100 cycles in by row 20
      push_fetch(9, 1'b1);
      line_start(1'b1, 9'd9);
      check("swap_before_overrun", 96'(frontBank), 96'(0));
      repeat (98) @(posedge clkPixel);
      #1;
      lineStart = 1'b1; fetchValid = 1'b1; fetchRow = 9'd20;
      check("overrun_clear_before", 96'(overrun), 96'(0));
      @(posedge clkPixel); #1;
      lineStart = 1'b0; fetchValid = 1'b0;
      fa_q.delete();
      lb_q.delete();
      push_fetch(20, 1'b1);
      check("overrun_set", 96'(overrun), 96'(1));
      check("overrun_no_toggle", 96'(frontBank), 96'(0));
      wait_fetch(n);
      check("refetch_in_time", 96'(n <= 170), 96'(1));

      // Reset during a fetch with a CPU read in flight
      push_fetch(12, 1'b0);
      line_start(1'b1, 9'd12);
      check("swap_before_reset", 96'(frontBank), 96'(1));
      repeat (10) @(posedge clkPixel);
      #1;
      cpuWe = 1'b0; cpuAddr = 16'h5000; cpuReq = 1'b1;
      n = 0;
      do begin
         @(negedge clkPixel);
         n++;
      end while (!(memRead && memAddr == 16'h5000) && n < 20);
      if (n >= 20) fail_now("cpu_grant_timeout");
      #1;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", all_outs(), '0);
      cpuReq = 1'b0;
      fa_q.delete();
      lb_q.delete();
      repeat (3) @(posedge clkPixel);
      #1;
      check("reset_hold_outputs", all_outs(), '0);
      reset = 1'b0;
      repeat (2) @(posedge clkPixel);

      push_fetch(5, 1'b1);
      line_start(1'b1, 9'd5);
      wait_fetch(n);
      check("fetch_after_reset_in_time", 96'(n <= 170), 96'(1));
      line_start(1'b1, 9'd5);
      check("swap_after_reset", 96'(frontBank), 96'(1));
      repeat (10) @(posedge clkPixel);
      check("cpu_queue_drained", 96'(cpu_q.size()), 96'(0));
      check("final_no_overrun", 96'(overrun), 96'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
